// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with a frame-synchronous shadow register.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg_out,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int unsigned BW = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);

  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_blank;
  logic          r_pending;
  logic [31:0]   r_sh_dig, r_dsp_dig;
  logic [7:0]    r_sh_en, r_dsp_en, r_sh_dp, r_dsp_dp;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [7:0]    r_an;
  logic          r_frame_done;

  logic          w_tick, w_wrap, w_active;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic [7:0]    w_lz;

  assign w_tick = (r_pcnt == PW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 3'd7);
  assign w_nib  = r_dsp_dig[{r_idx, 2'b00} +: 4];

  always_comb begin
    case (w_nib)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Leading-zero mask: walk down from position 7; disabled positions neither blank nor end the run.
  always_comb begin
    w_lz = '0;
`ifdef LZ_BLANK_EN
    begin
      logic        lead;
      int unsigned k;
      lead = 1'b1;
      for (int unsigned j = 0; j < 7; j++) begin
        k = 7 - j;
        if (r_dsp_en[k] && (r_dsp_dig[4*k +: 4] == 4'd0)) begin
          w_lz[k] = lead;
        end else if (r_dsp_en[k]) begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  assign w_active = (r_blank == '0) && r_dsp_en[r_idx] && !w_lz[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_blank      <= BW'(BLANK_CYC);
      r_pending    <= 1'b0;
      r_sh_dig     <= '0;
      r_sh_en      <= '0;
      r_sh_dp      <= '0;
      r_dsp_dig    <= '0;
      r_dsp_en     <= '0;
      r_dsp_dp     <= '0;
      r_seg        <= '1;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      if (w_tick) begin
        r_idx   <= r_idx + 3'd1;
        r_blank <= BW'(BLANK_CYC);
      end else if (r_blank != '0) begin
        r_blank <= r_blank - 1'b1;
      end

      if (load) begin
        r_sh_dig <= digits;
        r_sh_en  <= digit_en;
        r_sh_dp  <= dp_in;
      end
      // A load on the wrap tick bypasses the shadow so the new frame shows it immediately.
      if (load && w_wrap) begin
        r_dsp_dig <= digits;
        r_dsp_en  <= digit_en;
        r_dsp_dp  <= dp_in;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end else if (w_wrap && r_pending) begin
        r_dsp_dig <= r_sh_dig;
        r_dsp_en  <= r_sh_en;
        r_dsp_dp  <= r_sh_dp;
        r_pending <= 1'b0;
      end

      r_an         <= w_active ? ~(8'd1 << r_idx) : 8'hFF;
      r_seg        <= w_active ? w_seg : 7'h7F;
      r_dp         <= w_active ? ~r_dsp_dp[r_idx] : 1'b1;
      r_frame_done <= w_wrap;
    end
  end

  assign seg_out    = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (SCAN_DIV=4, BLANK_CYC=1); models LZ_BLANK_EN when defined.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg_out;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;

  seg_scan_driver #(.SCAN_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en),
    .dp_in(dp_in), .load(load), .seg_out(seg_out), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    int         s;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: m_s counts clock edges since reset release.
  bit          m_run = 0;
  int          m_s = 0;
  logic [31:0] m_dig, m_sdig;
  logic [7:0]  m_en, m_sen, m_dp, m_sdp;
  bit          m_pend;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
          7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
          7'b1111111};
    return t[n];
  endfunction

  function automatic bit lz_dark(input int p, input logic [31:0] d, input logic [7:0] e);
`ifdef LZ_BLANK_EN
    int h;
    h = -1;
    for (int k = 0; k < 8; k++)
      if (e[k] && d[4*k +: 4] != 4'd0) h = k;
    return (p != 0) && e[p] && (d[4*p +: 4] == 4'd0) && (p > h);
`else
    return (p < 0) && (d == 32'd0) && (e == 8'd0);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s = 0; m_pend = 0;
      m_dig = '0; m_en = '0; m_dp = '0;
      m_sdig = '0; m_sen = '0; m_sdp = '0;
    end else if (m_run) begin
      exp_t e;
      int pc, ix;
      pc = m_s % DIV;
      ix = (m_s / DIV) % 8;
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      e.fd = (m_s % (8 * DIV)) == (8 * DIV - 1);
      e.s  = m_s;
      if (pc >= BLANK && m_en[ix] && !lz_dark(ix, m_dig, m_en)) begin
        e.an  = 8'hFF;
        e.an[ix] = 1'b0;
        e.seg = dec(m_dig[4*ix +: 4]);
        e.dp  = ~m_dp[ix];
      end
      q.push_back(e);
      if (load) begin
        m_sdig = digits; m_sen = digit_en; m_sdp = dp_in;
        if (e.fd) begin
          m_dig = digits; m_en = digit_en; m_dp = dp_in; m_pend = 0;
        end else m_pend = 1;
      end else if (e.fd && m_pend) begin
        m_dig = m_sdig; m_en = m_sen; m_dp = m_sdp; m_pend = 0;
      end
      m_s++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks += 4;
      if (an !== e.an) begin
        n_fail++; $display("FAIL an s=%0d got %h exp %h", e.s, an, e.an);
      end
      if (seg_out !== e.seg) begin
        n_fail++; $display("FAIL seg_out s=%0d got %b exp %b", e.s, seg_out, e.seg);
      end
      if (dp !== e.dp) begin
        n_fail++; $display("FAIL dp s=%0d got %b exp %b", e.s, dp, e.dp);
      end
      if (frame_done !== e.fd) begin
        n_fail++; $display("FAIL frame_done s=%0d got %b exp %b", e.s, frame_done, e.fd);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    digits = d; digit_en = e; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_slot(input int ix, input int pc, input string nm);
    int b;
    b = 0;
    while (!(((m_s / DIV) % 8) == ix && (m_s % DIV) == pc) && b < 80) begin
      @(negedge clk); b++;
    end
    n_checks++;
    if (b >= 80) begin
      n_fail++; $display("FAIL %s timeout got %0d exp <80", nm, b);
    end
  endtask

  task automatic check_dark(input string nm);
    n_checks += 4;
    if (an !== 8'hFF)  begin n_fail++; $display("FAIL %s_an got %h exp ff", nm, an); end
    if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL %s_seg got %h exp 7f", nm, seg_out); end
    if (dp !== 1'b1)   begin n_fail++; $display("FAIL %s_dp got %b exp 1", nm, dp); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s_fd got %b exp 0", nm, frame_done); end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1 check_dark("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_run = 1;
    run(40);
  endtask

  task automatic test_full_load;
    wait_slot(2, 1, "full_wait");
    do_load(32'h76543210, 8'hFF, 8'h00);
    run(80);
  endtask

  task automatic test_midframe;
    wait_slot(3, 1, "mid_wait");
    do_load(32'h00000000, 8'hFF, 8'hA5);
    run(70);
  endtask

  task automatic test_wrap_load;
    wait_slot(7, DIV - 1, "wrap_wait");
    do_load(32'h00000009, 8'hFF, 8'h00);
    n_checks++;
    if (dut.r_pending !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pending got %b exp 0", dut.r_pending);
    end
    run(40);
  endtask

  task automatic test_blank_code;
    wait_slot(5, 2, "code_wait");
    do_load(32'h0000000C, 8'h01, 8'h01);
    run(72);
  endtask

  task automatic test_back_to_back;
    wait_slot(1, 0, "b2b_wait");
    do_load(32'h11111111, 8'h0F, 8'hFF);
    do_load(32'h89ABCDEF, 8'hF3, 8'h5A);
    run(72);
  endtask

  task automatic test_lz_and_async_reset;
    wait_slot(4, 2, "lz_wait");
    do_load(32'h00000305, 8'hFF, 8'hFF);
    run(72);
    do_load(32'h01020304, 8'hFF, 8'h00);
    wait_slot(2, 2, "arst_wait");
    #2 rst_n = 1'b0;
    #1 check_dark("arst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run(72);
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_midframe;
    test_wrap_load;
    test_blank_code;
    test_back_to_back;
    test_lz_and_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (at 100 MHz: 1 kHz per digit, 125 Hz frame); SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each digit slot (anti-ghosting); SHALL be < SCAN_DIV.
REQ-003 clk  in  1  single system clock; all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 digits  in  32  eight BCD nibbles; nibble k = digits[4k+3:4k] = digit position k (0 = rightmost).
REQ-006 digit_en  in  8  per-position enable; 0 forces that position dark.
REQ-007 dp_in  in  8  per-position decimal point request, active-high.
REQ-008 load  in  1  one-cycle strobe; captures digits/digit_en/dp_in into the shadow register.
REQ-009 seg_out  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 dp  out  1  active-low decimal point, registered.
REQ-011 an  out  8  active-low anodes, at most one bit low, registered.
REQ-012 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler pcnt SHALL count 0..SCAN_DIV-1 and wrap; tick = (pcnt == SCAN_DIV-1).
REQ-014 On tick, digit index idx (3 bits) SHALL advance idx+1, 7 wraps to 0; blank counter SHALL load BLANK_CYC.
REQ-015 Blank counter SHALL decrement by 1 each non-tick cycle while nonzero.
REQ-016 While blank counter != 0, an SHALL be 8'hFF, seg_out 7'h7F, dp 1.
REQ-017 Otherwise an[idx] SHALL be 0 (all other bits 1) if display digit_en[idx]=1; an SHALL be 8'hFF if digit_en[idx]=0.
REQ-018 seg_out decode of nibble idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10..15=1111111.
REQ-019 dp SHALL equal ~dp_in[idx] of the display register when the anode is active, else 1.
REQ-020 Outputs SHALL be registered: each reflects the idx/blank state of the previous cycle (one-cycle latency).
REQ-021 Shadow-register capture on load SHALL take effect the cycle after load; pending flag SHALL be set.
REQ-022 Display register SHALL update only on the tick where idx wraps 7->0, and only if pending=1; pending then clears. This prevents mid-frame tearing.
REQ-023 load coinciding with the wrap tick: the display register SHALL take the same-cycle load data directly; pending SHALL end cleared.
REQ-024 Multiple loads within one frame: the last one wins.
REQ-025 frame_done SHALL pulse on the cycle after every 7->0 wrap tick, whether or not pending was set.

Reset
REQ-026 rst_n low SHALL immediately force:
- pcnt=0, idx=0, blank counter=BLANK_CYC, pending=0.
- Shadow and display registers all 0, i.e. digit_en=0.
- an=8'hFF, seg_out=7'h7F, dp=1, frame_done=0.
REQ-027 Reset asserted mid-frame SHALL discard pending data; after release, scanning SHALL restart at idx 0 with a full slot of SCAN_DIV cycles.

Configuration
REQ-028 Macro LZ_BLANK_EN:
- When defined: leading-zero blanking. Starting at position 7 and moving down, enabled positions holding 0 SHALL be dark until the first nonzero enabled position. Position 0 is never blanked. Blanked positions SHALL also suppress dp.
- When undefined: every enabled position SHALL display its nibble.

Verification (SCAN_DIV=4, BLANK_CYC=1 unless noted)
REQ-029 Reset release, no load -> an=8'hFF for 40 cycles; frame_done every 32 cycles.
REQ-030 load digits=32'h76543210, digit_en=8'hFF, dp_in=0 -> from the next frame, an steps FE,FD,...,7F, one per 4 cycles. Each slot shows first cycle dark, then the matching segment codes, e.g. position 3 = 0110000.
REQ-031 load mid-frame (idx=3) with digits=0 -> the current frame is unchanged; new values appear after the next 7->0 wrap.
REQ-032 load on the exact wrap tick with digits=32'h00000009 -> the new data is displayed in that frame; pending reads 0.
REQ-033 Nibble 4'hC, digit_en=8'h01, dp_in=8'h01 -> slot 0 shows seg_out=1111111, dp=0; all other slots have an=8'hFF.
REQ-034 LZ_BLANK_EN defined, digits=32'h00000305, digit_en=8'hFF -> positions 7..3 dark; positions 2,1,0 show 3,0,5. Assert rst_n low mid-frame -> an=8'hFF asynchronously.
